io_input_cond: RTL and testbench

Frame-synchronous input conditioner that sits directly upstream of the custom I/O chip emulation. It synchronizes and debounces raw cabinet controls and suppresses opposing joystick directions. It shapes coin inserts into frame-counted pulses and generates the `UPDATE` strobe from VBLANK. `STKTRG12`, `CSTART12` and `DIPSW` change only on frame boundaries, so the I/O chip's edge detectors see clean, single-frame-resolved transitions.

---
 rtl/io_input_cond_if.sv | 28 ++
 rtl/io_input_cond.sv | 224 ++++++++++++++++++++++
 tb/tb_io_input_cond.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_input_cond_if.sv
// Purpose: raw cabinet controls in, frame-resolved controls and UPDATE strobe out.
// Latency: VBLANK rise to UPDATE rise is 4 CLK cycles; outputs move only at LATCH.
// Backpressure: none; the I/O chip samples on UPDATE and cannot stall the conditioner.
interface io_input_cond_if;
    logic        VBLANK;
    logic [5:0]  JOY1;
    logic [5:0]  JOY2;
    logic [1:0]  START;
    logic        COIN_IN;
    logic [23:0] DIPSW_IN;
    logic        UPDATE;
    logic [11:0] STKTRG12;
    logic [2:0]  CSTART12;
    logic [23:0] DIPSW;
    logic [1:0]  COIN_PENDING;

    // Cabinet / stimulus side: drives raw controls, observes conditioned results.
    modport master (
        output VBLANK, JOY1, JOY2, START, COIN_IN, DIPSW_IN,
        input  UPDATE, STKTRG12, CSTART12, DIPSW, COIN_PENDING
    );

    // Conditioner side.
    modport slave (
        input  VBLANK, JOY1, JOY2, START, COIN_IN, DIPSW_IN,
        output UPDATE, STKTRG12, CSTART12, DIPSW, COIN_PENDING
    );
endinterface

// File: rtl/io_input_cond.sv
// Purpose: sync, debounce, opposing-direction suppression, coin shaping, VBLANK-driven UPDATE.
// Latency: VBLANK rise +3 cycles to LATCH, UPDATE high from +4; raw to debounced 2 cycles + 4..5 ticks.
// Backpressure: none; coins beyond three queued are dropped.
module io_input_cond #(
    parameter int DEB_DIV     = 4096,
    parameter int COIN_FRAMES = 4,
    parameter int UPD_WIDTH   = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    io_input_cond_if.slave  io
);
    localparam int NB = 15;
    localparam int PW = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;

    // Bit map of the conditioned vector: [5:0] JOY1, [11:6] JOY2, [13:12] START, [14] COIN_IN.
    logic [NB-1:0]      raw;
    logic [NB-1:0]      sync1, sync2;
    logic               vb1, vb2, vb3;
    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic [NB-1:0][3:0] samp;
    logic [NB-1:0]      deb;
    logic               deb_coin_q;
    logic               coin_rise;
    logic               vb_rise;
    logic               coin_start;
    logic [1:0]         pending;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_PULSE} seq_t;
    typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} coin_t;

    seq_t        seq_state;
    coin_t       coin_state;
    logic [3:0]  coin_cnt;
    logic        coin;
    logic [3:0]  pulse_cnt;
    logic        update_r;
    logic [11:0] stk_r;
    logic [1:0]  start_r;
    logic [23:0] dip_r;

    assign raw = {io.COIN_IN, io.START, io.JOY2, io.JOY1};

    // Zero both directions of an axis when the player holds opposing directions.
    function automatic logic [5:0] suppress(input logic [5:0] j);
        logic [5:0] r;
        r = j;
        if (j[0] && j[2]) begin
            r[0] = 1'b0;
            r[2] = 1'b0;
        end
        if (j[1] && j[3]) begin
            r[1] = 1'b0;
            r[3] = 1'b0;
        end
        return r;
    endfunction

    // Two-flop synchronizers for all raw inputs, plus a third VBLANK stage for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            vb1   <= 1'b0;
            vb2   <= 1'b0;
            vb3   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            vb1   <= io.VBLANK;
            vb2   <= vb1;
            vb3   <= vb2;
        end
    end

    assign vb_rise = vb2 & ~vb3;
    assign tick    = (pre_cnt == PW'(DEB_DIV - 1));

    // Debounce sample prescaler: one tick every DEB_DIV cycles.
    always_ff @(posedge CLK) begin
        if (RESET)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Four-deep sample history per bit, advanced on each tick.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            samp <= '0;
        end else if (tick) begin
            for (int i = 0; i < NB; i++) samp[i] <= {samp[i][2:0], sync2[i]};
        end
    end

    // Debounced bit follows the samples only when all four agree, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            deb        <= '0;
            deb_coin_q <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (samp[i] == 4'hF)      deb[i] <= 1'b1;
                else if (samp[i] == 4'h0) deb[i] <= 1'b0;
            end
            deb_coin_q <= deb[14];
        end
    end

    assign coin_rise = deb[14] & ~deb_coin_q;

    // A coin issues at LATCH from idle, or straight out of the low gap when its count expires,
    // so back-to-back coins repeat every 2*COIN_FRAMES frames.
    always_comb begin
        coin_start = 1'b0;
        if (seq_state == S_LATCH && pending != 2'd0) begin
            if (coin_state == C_IDLE)
                coin_start = 1'b1;
            else if (coin_state == C_LOW && coin_cnt == 4'd1)
                coin_start = 1'b1;
        end
    end

    // Pending-coin queue, saturating at 3; simultaneous insert and issue leaves it unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending <= 2'd0;
        end else begin
            case ({coin_rise, coin_start})
                2'b10:   if (pending != 2'd3) pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase
        end
    end

    // Coin pulse shaper, stepped once per frame at LATCH.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            coin_state <= C_IDLE;
            coin_cnt   <= 4'd0;
            coin       <= 1'b0;
        end else if (seq_state == S_LATCH) begin
            case (coin_state)
                C_IDLE: begin
                    if (coin_start) begin
                        coin       <= 1'b1;
                        coin_cnt   <= 4'(COIN_FRAMES);
                        coin_state <= C_HIGH;
                    end
                end
                C_HIGH: begin
                    if (coin_cnt == 4'd1) begin
                        coin       <= 1'b0;
                        coin_cnt   <= 4'(COIN_FRAMES);
                        coin_state <= C_LOW;
                    end else begin
                        coin_cnt <= coin_cnt - 4'd1;
                    end
                end
                C_LOW: begin
                    if (coin_start) begin
                        coin       <= 1'b1;
                        coin_cnt   <= 4'(COIN_FRAMES);
                        coin_state <= C_HIGH;
                    end else if (coin_cnt == 4'd1) begin
                        coin_cnt   <= 4'd0;
                        coin_state <= C_IDLE;
                    end else begin
                        coin_cnt <= coin_cnt - 4'd1;
                    end
                end
                default: begin
                    coin_state <= C_IDLE;
                    coin       <= 1'b0;
                end
            endcase
        end
    end

    // Frame sequencer: latch all outputs in one cycle, then hold UPDATE for UPD_WIDTH cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            seq_state <= S_IDLE;
            pulse_cnt <= 4'd0;
            update_r  <= 1'b0;
            stk_r     <= '0;
            start_r   <= '0;
            dip_r     <= '0;
        end else begin
            case (seq_state)
                S_IDLE: begin
                    if (vb_rise) seq_state <= S_LATCH;
                end
                S_LATCH: begin
                    stk_r     <= {suppress(deb[11:6]), suppress(deb[5:0])};
                    start_r   <= deb[13:12];
                    dip_r     <= io.DIPSW_IN;
                    update_r  <= 1'b1;
                    pulse_cnt <= 4'(UPD_WIDTH - 1);
                    seq_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (pulse_cnt == 4'd0) begin
                        update_r  <= 1'b0;
                        seq_state <= S_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 4'd1;
                    end
                end
                default: begin
                    update_r  <= 1'b0;
                    seq_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.UPDATE       = update_r;
    assign io.STKTRG12     = stk_r;
    assign io.CSTART12     = {coin, start_r};
    assign io.DIPSW        = dip_r;
    assign io.COIN_PENDING = pending;
endmodule

// File: tb/tb_io_input_cond.sv
// Purpose: exercises io_input_cond with DEB_DIV=4, COIN_FRAMES=2, UPD_WIDTH=4.
// Latency: frames are driven with long stable input windows so results are frame-exact.
// Backpressure: not applicable.
module tb_io_input_cond;
    localparam int DEB = 4;
    localparam int CF  = 2;
    localparam int UW  = 4;

    logic CLK;
    logic RESET;
    int   total;
    int   bad;

    io_input_cond_if bus();

    io_input_cond #(.DEB_DIV(DEB), .COIN_FRAMES(CF), .UPD_WIDTH(UW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .io    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  j1;
        logic [5:0]  j2;
        logic [1:0]  st;
        logic [23:0] dip;
        logic [11:0] exp_stk;
        logic [2:0]  exp_cs;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference rule: a direction survives only if its opposite is not also held.
    function automatic logic [5:0] cond_ref(input logic [5:0] j);
        logic up, rt, dn, lf;
        up = j[0] && !j[2];
        dn = j[2] && !j[0];
        rt = j[1] && !j[3];
        lf = j[3] && !j[1];
        return {j[5], j[4], lf, dn, rt, up};
    endfunction

    // One VBLANK frame: 10 cycles high, 12 low; UPDATE must be seen for exactly UW cycles.
    task automatic do_frame();
        int n;
        n = 0;
        bus.VBLANK = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            if (k == 10) bus.VBLANK = 1'b0;
            if (bus.UPDATE) n++;
        end
        check("frame_update_len", n, UW);
    endtask

    task automatic press_coin();
        bus.COIN_IN = 1'b1;
        cyc(24);
        bus.COIN_IN = 1'b0;
        cyc(24);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        cyc(3);
        RESET = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{6'b001111, 6'b010101, 2'b00, 24'h000000, {6'b010000, 6'b000000}, 3'b000};
        vecs[1] = '{6'b000101, 6'b001010, 2'b11, 24'h123456, {6'b000000, 6'b000000}, 3'b011};
        vecs[2] = '{6'b110011, 6'b101100, 2'b01, 24'hA5A5A5, {6'b101100, 6'b110011}, 3'b001};
        vecs[3] = '{6'b111111, 6'b000000, 2'b10, 24'hFFFFFF, {6'b000000, 6'b110000}, 3'b010};
        vecs[4] = '{6'b000110, 6'b111010, 2'b00, 24'h0F0F0F, {6'b110000, 6'b000110}, 3'b000};

        // Reset with every raw control asserted.
        RESET        = 1'b1;
        bus.VBLANK   = 1'b0;
        bus.JOY1     = 6'h3F;
        bus.JOY2     = 6'h3F;
        bus.START    = 2'b11;
        bus.COIN_IN  = 1'b1;
        bus.DIPSW_IN = 24'hFFFFFF;
        cyc(3);
        check("rst_update",  bus.UPDATE, 0);
        check("rst_stk",     bus.STKTRG12, 0);
        check("rst_cstart",  bus.CSTART12, 0);
        check("rst_dipsw",   bus.DIPSW, 0);
        check("rst_pending", bus.COIN_PENDING, 0);
        RESET = 1'b0;
        do_frame();
        check("post_rst_stk",    bus.STKTRG12, 0);
        check("post_rst_cstart", bus.CSTART12, 0);

        bus.JOY1     = '0;
        bus.JOY2     = '0;
        bus.START    = '0;
        bus.COIN_IN  = 1'b0;
        bus.DIPSW_IN = '0;
        pulse_reset();
        cyc(40);

        // Debounce: a two-tick glitch is never reported; a stable level is.
        bus.JOY1[0] = 1'b1;
        cyc(2 * DEB);
        bus.JOY1[0] = 1'b0;
        cyc(30);
        do_frame();
        check("deb_glitch", bus.STKTRG12[0], 0);
        bus.JOY1[0] = 1'b1;
        cyc(8);
        do_frame();
        check("deb_early", bus.STKTRG12[0], 0);
        cyc(10);
        do_frame();
        check("deb_stable", bus.STKTRG12[0], 1);
        bus.JOY1 = '0;
        cyc(40);

        // Table of held input patterns.
        for (int i = 0; i < 5; i++) begin
            bus.JOY1     = vecs[i].j1;
            bus.JOY2     = vecs[i].j2;
            bus.START    = vecs[i].st;
            bus.DIPSW_IN = vecs[i].dip;
            cyc(40);
            do_frame();
            check($sformatf("vec%0d_stk", i), bus.STKTRG12, vecs[i].exp_stk);
            check($sformatf("vec%0d_cs", i),  bus.CSTART12, vecs[i].exp_cs);
            check($sformatf("vec%0d_dip", i), bus.DIPSW, vecs[i].dip);
        end

        // UPDATE shape: high in cycles 4..7 after the VBLANK rise.
        bus.VBLANK = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (k == 10) bus.VBLANK = 1'b0;
            check($sformatf("upd_shape_c%0d", k), bus.UPDATE, (k >= 4 && k <= 7) ? 1 : 0);
        end
        cyc(12);

        // A second VBLANK edge arriving during the pulse is dropped.
        begin
            int n;
            n = 0;
            bus.VBLANK = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                @(negedge CLK);
                if (k == 2)  bus.VBLANK = 1'b0;
                if (k == 4)  bus.VBLANK = 1'b1;
                if (k == 14) bus.VBLANK = 1'b0;
                if (bus.UPDATE) n++;
            end
            check("upd_second_edge_ignored", n, UW);
        end
        cyc(10);

        // DIPSW changes mid-frame are held off until the next LATCH.
        bus.DIPSW_IN = 24'hABCDEF;
        do_frame();
        check("dip_a", bus.DIPSW, 24'hABCDEF);
        begin
            int errs;
            errs = 0;
            bus.VBLANK = 1'b1;
            for (int k = 1; k <= 22; k++) begin
                @(negedge CLK);
                if (k == 5)  bus.DIPSW_IN = 24'h135790;
                if (k == 10) bus.VBLANK = 1'b0;
                if (bus.UPDATE && bus.DIPSW !== 24'hABCDEF) errs++;
            end
            check("dip_stable_during_update", errs, 0);
        end
        check("dip_held", bus.DIPSW, 24'hABCDEF);
        do_frame();
        check("dip_b", bus.DIPSW, 24'h135790);

        // Coins: four presses saturate the queue at three; three 2-high/2-low pulses follow.
        bus.JOY1  = '0;
        bus.JOY2  = '0;
        bus.START = '0;
        for (int i = 0; i < 4; i++) press_coin();
        cyc(10);
        check("coin_saturate", bus.COIN_PENDING, 3);
        for (int f = 0; f < 14; f++) begin
            int started;
            do_frame();
            started = (f / (2 * CF)) + 1;
            if (started > 3) started = 3;
            check($sformatf("coin_f%0d", f), bus.CSTART12[2],
                  (f < 3 * 2 * CF && (f % (2 * CF)) < CF) ? 1 : 0);
            check($sformatf("pend_f%0d", f), bus.COIN_PENDING, 3 - started);
        end

        // Reset mid-coin discards the queue and the active pulse.
        bus.JOY1 = 6'b010001;
        press_coin();
        press_coin();
        do_frame();
        check("abort_pre_coin", bus.CSTART12[2], 1);
        check("abort_pre_pend", bus.COIN_PENDING, 1);
        check("abort_pre_stk",  bus.STKTRG12, 12'b000000_010001);
        pulse_reset();
        @(negedge CLK);
        check("abort_pend",   bus.COIN_PENDING, 0);
        check("abort_cstart", bus.CSTART12, 0);
        check("abort_stk",    bus.STKTRG12, 0);
        bus.JOY1 = '0;
        cyc(40);
        do_frame();
        check("abort_no_coin", bus.CSTART12[2], 0);

        // Randomized held patterns against the reference rule.
        for (int i = 0; i < 16; i++) begin
            logic [5:0]  j1, j2;
            logic [1:0]  st;
            logic [23:0] dp;
            j1 = 6'($urandom);
            j2 = 6'($urandom);
            st = 2'($urandom);
            dp = 24'($urandom);
            bus.JOY1     = j1;
            bus.JOY2     = j2;
            bus.START    = st;
            bus.DIPSW_IN = dp;
            cyc(40);
            do_frame();
            check($sformatf("rnd%0d_stk", i), bus.STKTRG12, {cond_ref(j2), cond_ref(j1)});
            check($sformatf("rnd%0d_cs", i),  bus.CSTART12, {1'b0, st});
            check($sformatf("rnd%0d_dip", i), bus.DIPSW, dp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
